// File: rtl/alu_cmd_sequencer.sv
// Command FIFO and issue sequencer in front of a 4-bit opcode ALU.
// Commands are issued one at a time, and each ALU result is held on a valid/ready port.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int DW    = 4,
  parameter int OPW   = 4,
  parameter int RW    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DW-1:0]            in_a,
  input  logic [DW-1:0]            in_b,
  input  logic [OPW-1:0]           in_op,
  output logic [DW-1:0]            alu_a,
  output logic [DW-1:0]            alu_b,
  output logic [OPW-1:0]           alu_c,
  output logic                     alu_oe,
  input  logic [RW-1:0]            alu_y,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [RW-1:0]            res_data,
  output logic [OPW-1:0]           res_op,
  output logic                     res_err,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 * DW + OPW;
  localparam logic [OPW-1:0] OP_DIV = OPW'(5);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid never depends on ready, and a payload is held stable while valid waits for ready.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic push, pop;
  logic res_load, res_clear;
  logic divzero;

  // Registered count only, so a full FIFO refuses a push even when it pops that cycle.
  assign in_ready   = !rst && !flush && (count < CW'(DEPTH));
  assign push       = in_valid && in_ready;
  assign fifo_count = count;
  assign divzero    = (alu_c == OP_DIV) && (alu_b == '0);

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    alu_oe     = 1'b0;
    res_load   = 1'b0;
    res_clear  = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        alu_oe     = !divzero && !flush;
        res_load   = 1'b1;
        state_next = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          res_clear = 1'b1;
          if (count != '0) begin
            pop        = 1'b1;
            state_next = ISSUE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Storage array carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_a, in_b, in_op};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      alu_c  <= '0;
    end else if (flush) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_next;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr                <= rd_ptr + AW'(1);
        {alu_a, alu_b, alu_c} <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Result data/op/err survive a flush; only the valid flag is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_op    <= '0;
      res_err   <= 1'b0;
    end else if (flush) begin
      res_valid <= 1'b0;
    end else if (res_load) begin
      res_valid <= 1'b1;
      res_data  <= divzero ? '0 : alu_y;
      res_op    <= alu_c;
      res_err   <= divzero;
    end else if (res_clear) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU on the alu_* pins.
// Results are checked in order against an expected queue of {err, op, data}.
module tb_alu_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int DW    = 4;
  localparam int OPW   = 4;
  localparam int RW    = 16;
  localparam int EW    = 1 + OPW + RW;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_a, in_b;
  logic [OPW-1:0]  in_op;
  logic [DW-1:0]   alu_a, alu_b;
  logic [OPW-1:0]  alu_c;
  logic            alu_oe;
  logic [RW-1:0]   alu_y;
  logic            res_valid;
  logic            res_ready;
  logic [RW-1:0]   res_data;
  logic [OPW-1:0]  res_op;
  logic            res_err;
  logic [$clog2(DEPTH):0] fifo_count;

  int checks   = 0;
  int failures = 0;
  int oe_cnt   = 0;
  int oe0;
  logic [EW-1:0] exp_q[$];

  alu_cmd_sequencer #(.DEPTH(DEPTH), .DW(DW), .OPW(OPW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_oe(alu_oe), .alu_y(alu_y),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_op(res_op), .res_err(res_err),
    .fifo_count(fifo_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; divide by zero returns junk so the sequencer's forcing is visible.
  function automatic logic [RW-1:0] alu_model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [OPW-1:0] c);
    case (c)
      4'b0000: return RW'(a) + RW'(b);
      4'b0001: return RW'(a) - RW'(b);
      4'b0100: return RW'(a) * RW'(b);
      4'b0101: return (b == '0) ? 16'hDEAD : RW'(a / b);
      4'b1010: return RW'(a & b);
      default: return '0;
    endcase
  endfunction

  always_comb alu_y = alu_model(alu_a, alu_b, alu_c);

  always @(negedge clk) if (alu_oe === 1'b1) oe_cnt++;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [OPW-1:0] op);
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_results(input int budget, input bit check_gap);
    int last = -1;
    int cyc  = 0;
    logic [EW-1:0] exp;
    while (exp_q.size() > 0 && cyc < budget) begin
      if (res_valid && res_ready) begin
        exp = exp_q.pop_front();
        check("result", 32'({res_err, res_op, res_data}), 32'(exp));
        if (check_gap && last >= 0) check("result_gap", 32'(cyc - last), 32'd2);
        last = cyc;
      end
      tick();
      cyc++;
    end
    check("results_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    in_a = '0; in_b = '0; in_op = '0;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_alu_oe", 32'(alu_oe), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // 1: single add, latency and one-cycle oe pulse
    res_ready = 1'b1;
    oe0 = oe_cnt;
    push(4'd3, 4'd5, 4'b0000);
    check("t1_count", 32'(fifo_count), 32'd1);
    check("t1_oe_idle", 32'(alu_oe), 32'd0);
    tick();
    check("t1_oe_issue", 32'(alu_oe), 32'd1);
    check("t1_alu_a", 32'(alu_a), 32'd3);
    check("t1_valid_early", 32'(res_valid), 32'd0);
    tick();
    check("t1_res_valid", 32'(res_valid), 32'd1);
    check("t1_result", 32'({res_err, res_op, res_data}), 32'({1'b0, 4'b0000, 16'h0008}));
    check("t1_oe_hold", 32'(alu_oe), 32'd0);
    tick();
    check("t1_valid_drop", 32'(res_valid), 32'd0);
    check("t1_oe_pulses", 32'(oe_cnt - oe0), 32'd1);

    // 2: fill FIFO with consumer stalled, overflow attempt, drain in order
    res_ready = 1'b0;
    push(4'd1, 4'd2, 4'b0000);  exp_q.push_back({1'b0, 4'b0000, 16'd3});
    push(4'd4, 4'd4, 4'b0000);  exp_q.push_back({1'b0, 4'b0000, 16'd8});
    push(4'd7, 4'd1, 4'b0001);  exp_q.push_back({1'b0, 4'b0001, 16'd6});
    push(4'd3, 4'd3, 4'b0100);  exp_q.push_back({1'b0, 4'b0100, 16'd9});
    push(4'd6, 4'd2, 4'b0101);  exp_q.push_back({1'b0, 4'b0101, 16'd3});
    check("t2_full_count", 32'(fifo_count), 32'd4);
    check("t2_full_ready", 32'(in_ready), 32'd0);
    push(4'd15, 4'd15, 4'b0000);
    check("t2_overflow_count", 32'(fifo_count), 32'd4);
    res_ready = 1'b1;
    wait_results(30, 1'b1);
    tick();
    check("t2_empty_count", 32'(fifo_count), 32'd0);
    check("t2_no_extra", 32'(res_valid), 32'd0);

    // 3: divide by zero blocked, then a legal divide
    oe0 = oe_cnt;
    push(4'd9, 4'd0, 4'b0101);  exp_q.push_back({1'b1, 4'b0101, 16'h0000});
    wait_results(10, 1'b0);
    check("t3_divzero_oe", 32'(oe_cnt - oe0), 32'd0);
    oe0 = oe_cnt;
    push(4'd9, 4'd3, 4'b0101);  exp_q.push_back({1'b0, 4'b0101, 16'd3});
    wait_results(10, 1'b0);
    check("t3_div_oe", 32'(oe_cnt - oe0), 32'd1);

    // 4: multiply at operand maximum, op 1010 with b=0 is not blocked
    push(4'd15, 4'd15, 4'b0100); exp_q.push_back({1'b0, 4'b0100, 16'h00E1});
    push(4'd2, 4'd0, 4'b1010);   exp_q.push_back({1'b0, 4'b1010, 16'h0000});
    wait_results(15, 1'b0);

    // 5: flush in HOLD with two commands queued
    res_ready = 1'b0;
    push(4'd5, 4'd6, 4'b0000);
    push(4'd1, 4'd1, 4'b0000);
    push(4'd2, 4'd2, 4'b0000);
    check("t5_hold_valid", 32'(res_valid), 32'd1);
    check("t5_queued", 32'(fifo_count), 32'd2);
    flush = 1'b1;
    in_a = 4'd7; in_b = 4'd7; in_op = 4'b0000; in_valid = 1'b1;
    #1;
    check("t5_flush_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("t5_flush_valid", 32'(res_valid), 32'd0);
    check("t5_flush_count", 32'(fifo_count), 32'd0);
    check("t5_data_kept", 32'(res_data), 32'd11);
    oe0 = oe_cnt;
    repeat (4) tick();
    check("t5_no_oe", 32'(oe_cnt - oe0), 32'd0);
    check("t5_idle_count", 32'(fifo_count), 32'd0);
    check("t5_idle_valid", 32'(res_valid), 32'd0);

    // 6: asynchronous reset in ISSUE, then resume
    push(4'd2, 4'd3, 4'b0000);
    push(4'd4, 4'd1, 4'b0000);
    check("t6_issue_oe", 32'(alu_oe), 32'd1);
    check("t6_issue_count", 32'(fifo_count), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_oe", 32'(alu_oe), 32'd0);
    check("t6_async_valid", 32'(res_valid), 32'd0);
    check("t6_async_count", 32'(fifo_count), 32'd0);
    check("t6_async_ready", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b0;
    res_ready = 1'b1;
    push(4'd8, 4'd7, 4'b0000);   exp_q.push_back({1'b0, 4'b0000, 16'h000F});
    wait_results(10, 1'b0);
    check("t6_final_count", 32'(fifo_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
